// File: rtl/seg_scan_capture.sv
// Recovers a 4-digit frame from a multiplexed active-low seven-segment scan; SEG_HEX_EN adds A-F decode.
// Latency: frame_valid fires SETTLE_CYCLES+2 clocks after the anode edge of the last digit.
// Backpressure: none; the scan is free-running and each frame is a single-cycle strobe.
`timescale 1ns/1ps
module seg_scan_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  input  logic [3:0]  an_n,
  input  logic        clear_err,
  output logic [15:0] bcd_out,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        seg_err
);

  localparam logic [CNT_W-1:0] ACC_CNT = CNT_W'(SETTLE_CYCLES - 1);

  logic [11:0]      samp_q;
  logic [11:0]      prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       mask_q;
  logic [3:0]       mask_d;
  logic [3:0][3:0]  shadow_q;
  logic [3:0]       dp_sh_q;

  logic [3:0] an_q;
  logic       dp_q;
  logic [6:0] seg_q;
  logic       an_ok;
  logic [1:0] slot;
  logic       same;
  logic       accept;
  logic [4:0] dec;
  logic       dec_ok;
  logic [3:0] dec_code;

  // Returns {valid, code} for an active-high gfedcba pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
`ifdef SEG_HEX_EN
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
`endif
      default: return 5'b0_0000;
    endcase
  endfunction

  assign an_q  = samp_q[11:8];
  assign dp_q  = samp_q[7];
  assign seg_q = samp_q[6:0];
  assign same  = (samp_q == prev_q);

  assign dec      = seg_decode(~seg_q);
  assign dec_ok   = dec[4];
  assign dec_code = dec[3:0];

  always_comb begin
    an_ok = 1'b1;
    slot  = 2'd0;
    case (an_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  // Counter saturates at the accept value so one dwell yields exactly one accept.
  always_comb begin
    cnt_d = cnt_q;
    if (!an_ok || !same) begin
      cnt_d = '0;
    end else if (cnt_q != ACC_CNT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign accept = an_ok && (cnt_d == ACC_CNT) && !(same && (cnt_q == ACC_CNT));

  // A completed frame empties the mask; an accept in that same cycle starts the next one.
  always_comb begin
    mask_d = (mask_q == 4'hF) ? 4'h0 : mask_q;
    if (accept) begin
      if (dec_ok) begin
        mask_d[slot] = 1'b1;
      end else begin
        mask_d = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      samp_q <= {an_n, dp_n, seg_n};
      prev_q <= samp_q;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      dp_sh_q  <= '0;
    end else if (accept && dec_ok) begin
      shadow_q[slot] <= dec_code;
      dp_sh_q[slot]  <= ~dp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (mask_q == 4'hF);
      if (mask_q == 4'hF) begin
        bcd_out <= shadow_q;
        dp_out  <= dp_sh_q;
      end
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_err <= 1'b0;
    end else if (accept && !dec_ok) begin
      seg_err <= 1'b1;
    end else if (clear_err) begin
      seg_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: stimulus queues expected frames, a monitor pops them on frame_valid.
`timescale 1ns/1ps
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic        dp_n = 1'b1;
  logic [3:0]  an_n = 4'hF;
  logic        clear_err = 1'b0;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        seg_err;

  seg_scan_capture #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .clear_err   (clear_err),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .seg_err     (seg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one digit and hold it for cyc sampling edges.
  task automatic show(input logic [3:0] an, input logic [6:0] p, input logic dp, input int cyc);
    an_n  = an;
    seg_n = ~p;
    dp_n  = ~dp;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3, input logic [3:0] dps);
    show(4'b1110, pat(d0), dps[0], 8);
    show(4'b1101, pat(d1), dps[1], 8);
    show(4'b1011, pat(d2), dps[2], 8);
    show(4'b0111, pat(d3), dps[3], 8);
    show(4'b1111, 7'h00, 1'b0, 4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    frame_t e;
    if (rst_n && frame_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got bcd=%04h dp=%01h expected no frame", bcd_out, dp_out);
      end else begin
        e = exp_q.pop_front();
        if (bcd_out !== e.bcd || dp_out !== e.dp) begin
          errors++;
          $display("FAIL frame: got bcd=%04h dp=%01h expected bcd=%04h dp=%01h",
                   bcd_out, dp_out, e.bcd, e.dp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end of the stimulus");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_bcd", bcd_out, 0);
    chk("reset_dp", dp_out, 0);
    chk("reset_fv", frame_valid, 0);
    chk("reset_err", seg_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan 1,2,3,4
    exp_q.push_back({16'h4321, 4'h0});
    scan(1, 2, 3, 4, 4'h0);
    chk("t1_err", seg_err, 0);

    // Short first digit leaves slot 0 empty; a rescan completes on its digit 0
    show(4'b1110, pat(9), 1'b0, 3);
    show(4'b1101, pat(8), 1'b0, 8);
    show(4'b1011, pat(7), 1'b0, 8);
    show(4'b0111, pat(6), 1'b0, 8);
    exp_q.push_back({16'h6789, 4'h0});
    scan(9, 8, 7, 6, 4'h0);
    chk("t2_err", seg_err, 0);
    do_reset();

    // Invalid anode after three digits must not complete the frame
    show(4'b1110, pat(2), 1'b0, 8);
    show(4'b1101, pat(2), 1'b0, 8);
    show(4'b1011, pat(2), 1'b0, 8);
    show(4'b1100, pat(1), 1'b0, 10);
    exp_q.push_back({16'h3950, 4'b0100});
    scan(0, 5, 9, 3, 4'b0100);
    chk("t3_err", seg_err, 0);

    // Blank on digit 1 flags an error and discards the scan
    show(4'b1110, pat(1), 1'b0, 8);
    show(4'b1101, 7'h00, 1'b0, 8);
    show(4'b1011, pat(2), 1'b0, 8);
    show(4'b0111, pat(3), 1'b0, 8);
    chk("t4_err_set", seg_err, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
    chk("t4_err_clear", seg_err, 0);
    show(4'b1110, 7'h00, 1'b0, 4);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t4_set_wins", seg_err, 1);
    repeat (4) @(negedge clk);
    chk("t4_err_sticky", seg_err, 1);
    do_reset();

    // Hex pattern on digit 0
`ifdef SEG_HEX_EN
    exp_q.push_back({16'h321A, 4'h0});
`endif
    show(4'b1110, 7'h77, 1'b0, 8);
    show(4'b1101, pat(1), 1'b0, 8);
    show(4'b1011, pat(2), 1'b0, 8);
    show(4'b0111, pat(3), 1'b0, 8);
    show(4'b1111, 7'h00, 1'b0, 4);
`ifdef SEG_HEX_EN
    chk("t5_hex_err", seg_err, 0);
`else
    chk("t5_hex_err", seg_err, 1);
`endif
    do_reset();

    // Reset mid-frame, then scan in an order that would expose stale slots
    exp_q.push_back({16'h1234, 4'b0100});
    scan(4, 3, 2, 1, 4'b0100);
    show(4'b1110, pat(7), 1'b0, 8);
    show(4'b1101, pat(8), 1'b0, 8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_bcd", bcd_out, 0);
    chk("t6_rst_dp", dp_out, 0);
    chk("t6_rst_fv", frame_valid, 0);
    chk("t6_rst_err", seg_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({16'h1095, 4'h0});
    show(4'b1011, pat(0), 1'b0, 8);
    show(4'b0111, pat(1), 1'b0, 8);
    show(4'b1110, pat(5), 1'b0, 8);
    show(4'b1101, pat(9), 1'b0, 8);
    show(4'b1111, 7'h00, 1'b0, 6);
    chk("t6_err", seg_err, 0);

    repeat (10) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
